rotate_read_engine: RTL and testbench

Parametrised successor to the fixed 90°-CCW read controller. Once a frame has been written to SRAM, this block streams it out rotated by 0°, 90° CCW, 180° or 270° CCW, with the mode selected per frame. It works with a configurable SRAM read latency and a downstream ready/valid sink that can apply backpressure. It sits between the frame SRAM read port and the pixel output interface.

---
 rtl/rotate_read_engine.sv | 183 ++++++++++++++++++
 tb/tb_rotate_read_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rotate_read_engine.sv
// Streams a stored W x H frame out of SRAM rotated by 0/90/180/270 degrees CCW.
// Reads are credit-limited so a fixed-depth output FIFO absorbs any sink backpressure.
module rotate_read_engine #(
   parameter int unsigned W          = 256,
   parameter int unsigned H          = 256,
   parameter int unsigned DW         = 24,
   parameter int unsigned AW         = 20,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          Clk_in,
   input  logic          Reset,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          busy,
   output logic          read_finish,
   output logic          SRAM_EN_r,
   output logic          SRAM_WE_r,
   output logic [AW-1:0] SRAM_Addr_r,
   input  logic [DW-1:0] SRAM_Dout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_frame_start,
   output logic          out_line_end,
   output logic          out_frame_end
);
   localparam int unsigned CW = 13;
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] WM1 = CW'(W - 1);
   localparam logic [CW-1:0] HM1 = CW'(H - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;
   state_e state_q, state_d;

   logic [1:0]    mode_q;
   logic [CW-1:0] r_q, c_q, wo_m1, ho_m1, sr, sc;
   logic [AW-1:0] addr_d, addr_q;
   logic [2:0]    tag_d, tag_q;   // {frame_start, line_end, frame_end}
   logic          en_q;
   logic [RD_LAT-1:0] pipe_v_q;
   logic [2:0]    pipe_t_q [RD_LAT];
   logic [NW-1:0] fifo_cnt_q, inflight_q;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [DW+2:0] mem_q [FIFO_DEPTH];
   logic [DW+2:0] head;
   logic [31:0]   occupancy;
   logic          issue, credit, push, pop, row_end, last_req, drained;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign wo_m1    = mode_q[0] ? HM1 : WM1;
   assign ho_m1    = mode_q[0] ? WM1 : HM1;
   assign row_end  = (c_q == wo_m1);
   assign last_req = row_end && (r_q == ho_m1);
   assign tag_d    = {(r_q == '0) && (c_q == '0), row_end, last_req};

   always_comb begin
      sr = r_q;
      sc = c_q;
      unique case (mode_q)
         2'd0: begin sr = r_q;       sc = c_q;       end
         2'd1: begin sr = c_q;       sc = WM1 - r_q; end
         2'd2: begin sr = HM1 - r_q; sc = WM1 - c_q; end
         default: begin sr = HM1 - c_q; sc = r_q;    end
      endcase
      // Modular arithmetic: truncating operands first gives the same AW-bit result.
      addr_d = AW'(sr) * AW'(W) + AW'(sc);
   end

   assign pop     = out_valid && out_ready;
   assign push    = pipe_v_q[RD_LAT-1];
   // A slot freed by this cycle's pop is reusable immediately.
   assign occupancy = 32'(fifo_cnt_q) + 32'(inflight_q) - 32'(pop);
   assign credit  = (occupancy < FIFO_DEPTH);
   assign drained = (inflight_q == '0) && (fifo_cnt_q == '0);

   always_ff @(posedge Clk_in) begin
      if (Reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (credit && last_req) state_d = StDrain;
         StDrain: if (drained) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      issue       = 1'b0;
      busy        = 1'b0;
      read_finish = 1'b0;
      case (state_q)
         StIssue: begin
            busy  = 1'b1;
            issue = credit;
         end
         StDrain: begin
            busy        = !drained;
            read_finish = drained;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         mode_q <= '0;
         r_q    <= '0;
         c_q    <= '0;
         en_q   <= 1'b0;
         addr_q <= '0;
         tag_q  <= '0;
      end else begin
         en_q <= issue;
         if (state_q == StIdle && start) begin
            mode_q <= mode;
            r_q    <= '0;
            c_q    <= '0;
         end
         if (issue) begin
            addr_q <= addr_d;
            tag_q  <= tag_d;
            if (row_end) begin
               c_q <= '0;
               r_q <= r_q + CW'(1);
            end else begin
               c_q <= c_q + CW'(1);
            end
         end
      end
   end

   assign SRAM_EN_r   = en_q;
   assign SRAM_WE_r   = 1'b0;
   assign SRAM_Addr_r = addr_q;

   // Read-latency shadow pipe; clearing it on reset discards returning stale data.
   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         pipe_v_q <= '0;
      end else begin
         pipe_v_q[0] <= en_q;
         for (int k = 1; k < RD_LAT; k++) pipe_v_q[k] <= pipe_v_q[k-1];
      end
   end

   always_ff @(posedge Clk_in) begin
      pipe_t_q[0] <= tag_q;
      for (int k = 1; k < RD_LAT; k++) pipe_t_q[k] <= pipe_t_q[k-1];
   end

   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         inflight_q <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_q + NW'(push) - NW'(pop);
         inflight_q <= inflight_q + NW'(issue) - NW'(push);
      end
   end

   always_ff @(posedge Clk_in) begin
      if (push) mem_q[wr_ptr_q] <= {pipe_t_q[RD_LAT-1], SRAM_Dout};
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (fifo_cnt_q != '0);
   assign out_data  = out_valid ? head[DW-1:0] : '0;
   assign {out_frame_start, out_line_end, out_frame_end} = out_valid ? head[DW+2:DW] : 3'b000;

endmodule

// File: tb/tb_rotate_read_engine.sv
// Bench for rotate_read_engine: latency SRAM model, random sink stalls, and an
// index-arithmetic reference for rotated pixel order and markers.
module tb_rotate_read_engine;
   localparam int unsigned W = 4, H = 3, DW = 24, AW = 20, RD_LAT = 2, FIFO_DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst, start, out_ready;
   logic [1:0]    mode;
   logic          busy, read_finish, SRAM_EN_r, SRAM_WE_r, out_valid;
   logic [AW-1:0] SRAM_Addr_r;
   logic [DW-1:0] SRAM_Dout, out_data;
   logic          out_frame_start, out_line_end, out_frame_end;
   logic [7:0]    salt;
   logic [DW-1:0] sram_pipe [RD_LAT];
   int            n_checks = 0, n_fail = 0;
   logic [15:0]   first_px, last_px;

   always #5 clk = ~clk;

   rotate_read_engine #(
      .W(W), .H(H), .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .Clk_in(clk), .Reset(rst), .start(start), .mode(mode), .busy(busy),
      .read_finish(read_finish), .SRAM_EN_r(SRAM_EN_r), .SRAM_WE_r(SRAM_WE_r),
      .SRAM_Addr_r(SRAM_Addr_r), .SRAM_Dout(SRAM_Dout), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_frame_start(out_frame_start),
      .out_line_end(out_line_end), .out_frame_end(out_frame_end)
   );

   // SRAM: word = {salt, address}; garbage when not enabled.
   always @(posedge clk) begin
      sram_pipe[0] <= SRAM_EN_r ? {salt, 16'(SRAM_Addr_r)} : DW'($urandom);
      for (int k = 1; k < RD_LAT; k++) sram_pipe[k] <= sram_pipe[k-1];
   end
   assign SRAM_Dout = sram_pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] model(input int m, input int k, input logic [7:0] s);
      int wo, ho, r, c, sr, sc;
      wo = (m % 2 == 1) ? H : W;
      ho = (m % 2 == 1) ? W : H;
      r  = k / wo;
      c  = k % wo;
      case (m)
         0: begin sr = r;         sc = c;         end
         1: begin sr = c;         sc = W - 1 - r; end
         2: begin sr = H - 1 - r; sc = W - 1 - c; end
         default: begin sr = H - 1 - c; sc = r;   end
      endcase
      return {k == 0, c == wo - 1, k == wo * ho - 1, s, 16'(sr * W + sc)};
   endfunction

   // rdy_kind: 0 always ready, 1 random, 2 stalled for the first 20 cycles
   task automatic run_frame(input logic [1:0] m, input int rdy_kind, input int glitch_at,
                            input bit start_on_finish, input bit check_b2b,
                            output logic [15:0] fpx, output logic [15:0] lpx);
      logic [26:0] got [$];
      logic [26:0] word, prev_word;
      int n_fin = 0, fin_at = -1, last_hs = -1, first_v = -1, n_valid = 0;
      int en_cnt = 0, hs_cnt = 0, en_win = 0;
      bit prev_stall = 0, done = 0;
      prev_word = '0;
      salt  = 8'($urandom_range(0, 127));
      mode  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 2'($urandom);
      check("busy_after_start", busy, 1);
      for (int cy = 0; cy < 400; cy++) begin
         if (fin_at >= 0 && cy == fin_at + 1) begin
            done = 1;
            break;
         end
         word = {out_frame_start, out_line_end, out_frame_end, out_data};
         if (prev_stall) check("stall_hold", {out_valid, word}, {1'b1, prev_word});
         if (SRAM_EN_r) en_cnt++;
         check("outstanding", (en_cnt - hs_cnt) <= FIFO_DEPTH, 1);
         case (rdy_kind)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom);
            default: out_ready = (cy >= 20);
         endcase
         if (rdy_kind == 2 && cy < 20 && SRAM_EN_r) en_win++;
         if (out_valid && first_v < 0) first_v = cy;
         if (out_valid) n_valid++;
         if (out_valid && out_ready) begin
            got.push_back(word);
            last_hs = cy;
            hs_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = word;
         if (read_finish) begin
            n_fin++;
            if (fin_at < 0) fin_at = cy;
         end
         if (cy == glitch_at) begin
            start = 1'b1;
            mode  = m ^ 2'd1;
         end else begin
            start = 1'b0;
         end
         if (read_finish && start_on_finish) start = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("frame_done", done, 1);
      check("idle_after_finish", busy, 0);
      check("finish_single", read_finish, 0);
      check("finish_pulses", n_fin, 1);
      check("finish_timing", fin_at - last_hs, 1);
      check("pixel_count", got.size(), W * H);
      for (int k = 0; k < got.size() && k < W * H; k++)
         check($sformatf("pix_m%0d_k%0d", m, k), got[k], model(m, k, salt));
      if (check_b2b) begin
         check("b2b_valid_cycles", n_valid, W * H);
         check("b2b_span", last_hs - first_v, W * H - 1);
      end
      if (rdy_kind == 2) check("stall_en_limit", en_win <= FIFO_DEPTH, 1);
      fpx = (got.size() > 0) ? got[0][15:0] : 16'hFFFF;
      lpx = (got.size() > 0) ? got[got.size()-1][15:0] : 16'hFFFF;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0; out_ready = 1'b0; salt = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {busy, read_finish, SRAM_EN_r, SRAM_WE_r, out_valid,
                         out_frame_start, out_line_end, out_frame_end}, 0);
      check("rst_addr", SRAM_Addr_r, 0);
      check("rst_data", out_data, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_frame(2'd0, 0, -1, 0, 1, first_px, last_px);
      check("m0_first", first_px, 0);
      check("m0_last", last_px, 11);
      run_frame(2'd1, 0, -1, 0, 1, first_px, last_px);
      check("m1_first", first_px, 3);
      check("m1_last", last_px, 8);
      run_frame(2'd2, 0, -1, 0, 1, first_px, last_px);
      check("m2_first", first_px, 11);
      check("m2_last", last_px, 0);
      run_frame(2'd3, 0, -1, 0, 1, first_px, last_px);
      check("m3_first", first_px, 8);
      check("m3_last", last_px, 3);

      run_frame(2'd1, 2, -1, 0, 0, first_px, last_px);
      run_frame(2'd0, 1, 3, 0, 0, first_px, last_px);
      run_frame(2'd3, 0, -1, 1, 0, first_px, last_px);
      run_frame(2'd2, 1, -1, 0, 0, first_px, last_px);

      // Abort mid-frame with reads in flight; stale salt 0xA5 must never surface.
      salt = 8'hA5; mode = 2'd0; start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_ctrl", {busy, read_finish, SRAM_EN_r, SRAM_WE_r, out_valid,
                            out_frame_start, out_line_end, out_frame_end}, 0);
      check("midrst_addr", SRAM_Addr_r, 0);
      check("midrst_data", out_data, 0);
      run_frame(2'd2, 0, -1, 0, 0, first_px, last_px);
      check("post_rst_first", first_px, 11);

      for (int i = 0; i < 10; i++) run_frame(2'($urandom), 1, -1, 0, 0, first_px, last_px);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
